motion_vector_recon: RTL and testbench
======================================

Name: motion_vector_recon

Overview:
- Downstream consumer of the motion-code decoder in the MPEG macroblock path.
- Takes the decoded motion_code for each vector component, plus the bitstream window that follows it, and extracts the motion_residual (r_size bits).
- Reconstructs each component against the stored predictor (PMV), wraps it into the f_code range, and updates the PMV registers.
- Emits a reconstructed (horizontal, vertical) vector pair per request, with ready/valid handshakes on both sides.

Parameters:
- MV_W, 13, signed width of PMV registers and output vectors; covers −4096..4095 for f_code 9.
- MAX_RSIZE, 8, maximum r_size; equals the width of res_win.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- pmv_clear  input  1  zero all four PMVs (slice start / intra MB)
- start  input  1  begin one vector (H then V); sampled only in IDLE
- sel  input  1  vector index s (0 = first, 1 = second)
- mirror  input  1  when sel=0, also write the result into PMV[1][*]; sampled with start
- f_code_h  input  4  horizontal f_code, legal 1..9
- f_code_v  input  4  vertical f_code, legal 1..9
- in_valid  input  1  mcode/res_win valid
- in_ready  output  1  block accepts a component
- mcode  input  6  signed motion_code, −16..16
- res_win  input  MAX_RSIZE  bitstream bits following the motion code, MSB first
- res_len  output  4  residual bits consumed on this handshake; combinational
- out_valid  output  1  mv_h/mv_v valid
- out_ready  input  1  downstream accepts
- mv_h  output  MV_W  reconstructed horizontal component, signed
- mv_v  output  MV_W  reconstructed vertical component, signed
- err  output  1  sticky: illegal f_code or |mcode|>16 seen; cleared by rst or pmv_clear

Behaviour:
- Reset: FSM=IDLE; all PMVs=0; in_ready=0; out_valid=0; mv_h=mv_v=0; err=0.
- FSM states: IDLE, GET_H, GET_V, OUT.
  - IDLE: start → GET_H. sel and mirror are latched on this cycle; f_code_h/f_code_v are sampled at each component's handshake.
  - GET_H: in_ready=1. A handshake (in_valid & in_ready) computes the H component, registers it into mv_h and PMV[sel][0] → GET_V.
  - GET_V: same as GET_H, using f_code_v and PMV[sel][1] → OUT.
  - OUT: out_valid=1; mv_h/mv_v held stable; out_valid & out_ready → IDLE.
  - in_ready=0 in IDLE and OUT.
- Minimum latency: start to out_valid is 3 cycles when in_valid is held high.
- Per-component arithmetic, with p = stored PMV:
  - r = f_code−1; f = 1<<r.
  - If r==0 or mcode==0: delta = mcode; res_len = 0.
  - Otherwise: resid = top r bits of res_win (unsigned); delta = ((|mcode|−1)<<r) + resid + 1, negated when mcode<0; res_len = r.
  - Compute n = p + delta at MV_W+1 bits.
  - If n < −16f: n += 32f. Else if n > 16f−1: n −= 32f.
  - Store n in the PMV and drive it on the output.
- res_len is valid whenever in_valid is high in GET_H/GET_V, and 0 otherwise. Upstream shifts its window by res_len only on the handshake cycle.
- Mirror: when the latched sel=0 and latched mirror=1, the PMV[0][t] write also writes PMV[1][t] in the same cycle.
- Illegal f_code (0 or >9) or |mcode|>16:
  - set err;
  - treat the component as delta=0 with res_len=0;
  - the handshake still completes.
- pmv_clear:
  - highest priority after rst;
  - zeroes all PMVs and err;
  - if asserted while not in IDLE, aborts to IDLE: out_valid drops next cycle, no further PMV write;
  - a start in the same cycle is ignored.
- start while not IDLE is ignored.
- Backpressure: in OUT, mv_h/mv_v/out_valid stay constant until out_ready; no input is accepted.

Test Plan:
1. Basic reconstruction: f_code_h=f_code_v=1, PMV=0, start sel=0, mcode H=+3 then V=−2 → mv=(3,−2), res_len=0 on both handshakes, out_valid 3 cycles after start.
2. Residual extraction: f_code_h=2, mcode=+2, res_win=8'b1xxxxxxx → res_len=1, delta=4, mv_h=4.
3. Positive wrap: f_code=1; first vector mcode H=+14 → 14; second vector (same sel) mcode H=+5 → 19 wraps to −13.
4. Negative wrap:
   - Setup: f_code=1, mcode H=−16 → −16.
   - Stimulus: next vector mcode H=−1.
   - Result: −17 wraps to 15.
5. Abort and mirror:
   - Start sel=0 mirror=1, H accepted with +7, pmv_clear asserted in GET_V → IDLE, no out_valid, all PMVs 0.
   - Repeat without the clear → PMV[1][0]=7 is also written.
6. Backpressure and error:
   - out_ready low 3 cycles in OUT → mv and out_valid stable, in_ready=0.
   - f_code_h=0 → err=1, H delta=0, handshake completes.

Source files
------------

// File: rtl/motion_vector_recon_if.sv
// Handshake bundle between the motion-code decoder, the vector reconstructor and
// the downstream consumer of reconstructed (H, V) vector pairs.
interface motion_vector_recon_if #(
  parameter int MV_W      = 13,
  parameter int MAX_RSIZE = 8
) ();
  logic                   pmv_clear;
  logic                   start;
  logic                   sel;
  logic                   mirror;
  logic [3:0]             f_code_h;
  logic [3:0]             f_code_v;
  logic                   in_valid;
  logic                   in_ready;
  logic [5:0]             mcode;
  logic [MAX_RSIZE-1:0]   res_win;
  logic [3:0]             res_len;
  logic                   out_valid;
  logic                   out_ready;
  logic [MV_W-1:0]        mv_h;
  logic [MV_W-1:0]        mv_v;
  logic                   err;

  modport master (
    output pmv_clear, start, sel, mirror, f_code_h, f_code_v,
           in_valid, mcode, res_win, out_ready,
    input  in_ready, res_len, out_valid, mv_h, mv_v, err
  );

  modport slave (
    input  pmv_clear, start, sel, mirror, f_code_h, f_code_v,
           in_valid, mcode, res_win, out_ready,
    output in_ready, res_len, out_valid, mv_h, mv_v, err
  );
endinterface

// File: rtl/motion_vector_recon.sv
// MPEG motion vector reconstruction: residual extraction, PMV prediction,
// f_code range wrapping and PMV update for one (H, V) vector per start.
module motion_vector_recon #(
  parameter int MV_W      = 13,
  parameter int MAX_RSIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  motion_vector_recon_if.slave   bus
);

  // two spare bits: p + delta needs MV_W+1, and 32f reaches 8192 for f_code 9
  localparam int NW = MV_W + 2;

  typedef enum logic [1:0] {IDLE, GET_H, GET_V, OUT} state_t;

  typedef struct packed {
    logic                   ok;
    logic [3:0]             len;
    logic signed [MV_W-1:0] n;
  } comp_t;

  state_t                             state_q, state_d;
  logic                               sel_q, sel_d;
  logic                               mirror_q, mirror_d;
  logic [1:0][1:0][MV_W-1:0]          pmv_q, pmv_d;
  logic [MV_W-1:0]                    mv_h_q, mv_h_d;
  logic [MV_W-1:0]                    mv_v_q, mv_v_d;
  logic                               err_q, err_d;

  logic                               in_ready;
  logic                               hs;
  logic                               t;
  logic [3:0]                         fc;
  comp_t                              comp;

  function automatic comp_t recon(input logic [3:0]           fcode,
                                  input logic signed [5:0]    mc,
                                  input logic [MAX_RSIZE-1:0] win,
                                  input logic signed [MV_W-1:0] p);
    comp_t                  c;
    logic [3:0]             r;
    logic [5:0]             mag;
    logic [MAX_RSIZE-1:0]   resid;
    logic signed [NW-1:0]   f, lo, hi, span, delta, n;
    mag   = mc[5] ? 6'(-mc) : 6'(mc);
    c.ok  = (fcode >= 4'd1) && (fcode <= 4'd9) && (mag <= 6'd16);
    r     = fcode - 4'd1;
    f     = NW'(1) << r;
    lo    = -(f <<< 4);
    hi    = (f <<< 4) - NW'(1);
    span  = f <<< 5;
    resid = win >> (MAX_RSIZE - int'(r));
    if (r == 4'd0 || mc == 6'sd0) begin
      delta = NW'(mc);
      c.len = 4'd0;
    end else begin
      delta = ((NW'(mag) - NW'(1)) << r) + NW'(resid) + NW'(1);
      if (mc[5]) delta = -delta;
      c.len = r;
    end
    n = NW'(p) + delta;
    if (n < lo)      n = n + span;
    else if (n > hi) n = n - span;
    // illegal syntax element: keep the predictor, consume nothing
    if (!c.ok) begin
      c.len = 4'd0;
      n     = NW'(p);
    end
    c.n = MV_W'(n);
    return c;
  endfunction

  assign in_ready = (state_q == GET_H) || (state_q == GET_V);
  assign hs       = bus.in_valid && in_ready;
  assign t        = (state_q == GET_V);
  assign fc       = t ? bus.f_code_v : bus.f_code_h;

  always_comb begin
    comp = recon(fc, bus.mcode, bus.res_win, pmv_q[sel_q][t]);
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mirror_d = mirror_q;
    pmv_d    = pmv_q;
    mv_h_d   = mv_h_q;
    mv_v_d   = mv_v_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = GET_H;
        sel_d    = bus.sel;
        mirror_d = bus.mirror;
      end
      GET_H, GET_V: if (hs) begin
        if (t) mv_v_d = comp.n;
        else   mv_h_d = comp.n;
        pmv_d[sel_q][t] = comp.n;
        if (!sel_q && mirror_q) pmv_d[1][t] = comp.n;
        if (!comp.ok) err_d = 1'b1;
        state_d = t ? OUT : GET_V;
      end
      OUT: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // clear wins over any in-flight write and over a same-cycle start
    if (bus.pmv_clear) begin
      pmv_d   = '0;
      err_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      mirror_q <= 1'b0;
      pmv_q    <= '0;
      mv_h_q   <= '0;
      mv_v_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      mirror_q <= mirror_d;
      pmv_q    <= pmv_d;
      mv_h_q   <= mv_h_d;
      mv_v_q   <= mv_v_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.res_len   = hs ? comp.len : 4'd0;
  assign bus.out_valid = (state_q == OUT);
  assign bus.mv_h      = mv_h_q;
  assign bus.mv_v      = mv_v_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_motion_vector_recon.sv
// Directed bench for motion_vector_recon: expected vector pairs queued at
// stimulus time and checked when the block presents them.
module tb_motion_vector_recon;
  localparam int MV_W = 13;
  localparam int MAX_RSIZE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motion_vector_recon_if #(.MV_W(MV_W), .MAX_RSIZE(MAX_RSIZE)) bus ();
  motion_vector_recon #(.MV_W(MV_W), .MAX_RSIZE(MAX_RSIZE)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct { int h; int v; } mv_t;
  mv_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    bus.pmv_clear = 1'b1; cyc(); bus.pmv_clear = 1'b0;
  endtask

  task automatic send(input logic [5:0] mc, input logic [7:0] win, input int len);
    bus.in_valid = 1'b1; bus.mcode = mc; bus.res_win = win;
    #1;
    chk("in_ready", bus.in_ready, 1);
    chk("res_len", bus.res_len, len);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_vec(input logic s, input logic mir, input logic [3:0] fh,
                           input logic [3:0] fv, input logic [5:0] mch,
                           input logic [7:0] winh, input int lh,
                           input logic [5:0] mcv, input logic [7:0] winv,
                           input int lv, input int eh, input int ev);
    bus.f_code_h = fh; bus.f_code_v = fv;
    bus.sel = s; bus.mirror = mir; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    send(mch, winh, lh);
    send(mcv, winv, lv);
    chk("latency_out_valid", bus.out_valid, 1);
    sb.push_back('{eh, ev});
  endtask

  task automatic recv();
    mv_t e;
    for (int n = 0; n < 8 && !bus.out_valid; n++) cyc();
    if (!bus.out_valid) begin
      chk("out_valid_timeout", bus.out_valid, 1);
      return;
    end
    e = sb.pop_front();
    chk("mv_h", $signed(bus.mv_h), e.h);
    chk("mv_v", $signed(bus.mv_v), e.v);
    bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
  endtask

  task automatic vec(input logic s, input logic mir, input logic [3:0] fh,
                     input logic [3:0] fv, input logic [5:0] mch,
                     input logic [7:0] winh, input int lh,
                     input logic [5:0] mcv, input logic [7:0] winv,
                     input int lv, input int eh, input int ev);
    drive_vec(s, mir, fh, fv, mch, winh, lh, mcv, winv, lv, eh, ev);
    recv();
  endtask

  initial begin
    bus.pmv_clear = 0; bus.start = 0; bus.sel = 0; bus.mirror = 0;
    bus.f_code_h = 1; bus.f_code_v = 1; bus.in_valid = 0; bus.mcode = 0;
    bus.res_win = 0; bus.out_ready = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mv_h", $signed(bus.mv_h), 0);
    chk("rst_mv_v", $signed(bus.mv_v), 0);
    chk("rst_err", bus.err, 0);
    chk("rst_res_len", bus.res_len, 0);

    // basic reconstruction and single-bit residual
    vec(0, 0, 1, 1, 6'sd3, 8'h00, 0, -6'sd2, 8'h00, 0, 3, -2);
    vec(1, 0, 2, 1, 6'sd2, 8'h80, 1, 6'sd0, 8'h00, 0, 4, 0);
    chk("err_clean", bus.err, 0);

    // positive wrap
    clear();
    vec(0, 0, 1, 1, 6'sd14, 8'h00, 0, 6'sd0, 8'h00, 0, 14, 0);
    vec(0, 0, 1, 1, 6'sd5, 8'h00, 0, 6'sd0, 8'h00, 0, -13, 0);

    // negative wrap
    clear();
    vec(0, 0, 1, 1, -6'sd16, 8'h00, 0, 6'sd0, 8'h00, 0, -16, 0);
    vec(0, 0, 1, 1, -6'sd1, 8'h00, 0, 6'sd0, 8'h00, 0, 15, 0);

    // full-width residual at f_code 9, multi-bit residual, negative residual
    clear();
    vec(1, 0, 9, 3, -6'sd16, 8'hFF, 8, 6'sd1, 8'hC0, 2, -4096, 4);
    vec(0, 0, 3, 1, -6'sd2, 8'h7F, 2, 6'sd0, 8'h00, 0, -6, 0);

    // start coinciding with clear is dropped
    bus.start = 1'b1; bus.pmv_clear = 1'b1; cyc();
    bus.start = 1'b0; bus.pmv_clear = 1'b0;
    chk("clear_start_ignored", bus.in_ready, 0);

    // abort in GET_V
    bus.f_code_h = 1; bus.f_code_v = 1;
    bus.sel = 0; bus.mirror = 1; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    send(6'sd7, 8'h00, 0);
    bus.pmv_clear = 1'b1; cyc(); bus.pmv_clear = 1'b0;
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    cyc();
    chk("abort_out_valid2", bus.out_valid, 0);
    vec(0, 0, 1, 1, 6'sd0, 8'h00, 0, 6'sd0, 8'h00, 0, 0, 0);
    vec(1, 0, 1, 1, 6'sd0, 8'h00, 0, 6'sd0, 8'h00, 0, 0, 0);

    // mirror writes PMV[1] too
    vec(0, 1, 1, 1, 6'sd7, 8'h00, 0, 6'sd0, 8'h00, 0, 7, 0);
    vec(1, 0, 1, 1, 6'sd0, 8'h00, 0, 6'sd0, 8'h00, 0, 7, 0);

    // backpressure
    drive_vec(1, 0, 1, 1, 6'sd1, 8'h00, 0, 6'sd1, 8'h00, 0, 8, 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_mv_h", $signed(bus.mv_h), 8);
      chk("bp_mv_v", $signed(bus.mv_v), 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_res_len", bus.res_len, 0);
    end
    bus.in_valid = 1'b0;
    recv();

    // illegal f_code: delta 0, handshake completes, err sticks
    vec(1, 0, 0, 1, 6'sd5, 8'hFF, 0, 6'sd0, 8'h00, 0, 8, 1);
    chk("err_fcode", bus.err, 1);
    clear();
    chk("err_cleared", bus.err, 0);

    // illegal motion code magnitude
    vec(1, 0, 1, 1, 6'sd17, 8'h00, 0, 6'sd0, 8'h00, 0, 0, 0);
    chk("err_mcode", bus.err, 1);
    clear();
    chk("err_cleared2", bus.err, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
